// File: rtl/parking_pkg.sv
// Shared types and constants for the parking billing block.
package parking_pkg;

  localparam int          TIME_W     = 8;
  localparam int          MULT_STEPS = 8;
  localparam logic [7:0]  FEE_MAX    = 8'd255;

  localparam logic SLOT_P = 1'b0;
  localparam logic SLOT_Q = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } bill_state_e;

  function automatic logic [TIME_W-1:0] sat_fee(input logic [2*TIME_W-1:0] p);
    return (p > {{TIME_W{1'b0}}, FEE_MAX}) ? FEE_MAX : p[TIME_W-1:0];
  endfunction

endpackage

// File: rtl/fee_mult.sv
// Serial shift-add multiplier: one partial product per clock, eight clocks per operation.
// product/done are combinational so the caller can latch the final sum on the last step's edge.
module fee_mult
  import parking_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [TIME_W-1:0]     a,
  input  logic [TIME_W-1:0]     b,
  output logic                  done,
  output logic [2*TIME_W-1:0]   product
);

  logic                  running;
  logic [2:0]            step;
  logic [2*TIME_W-1:0]   acc;
  logic [2*TIME_W-1:0]   mcand;
  logic [TIME_W-1:0]     mplier;

  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = running && (step == 3'(MULT_STEPS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      running <= 1'b0;
      step    <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (start) begin
      running <= 1'b1;
      step    <= '0;
      acc     <= '0;
      mcand   <= {{TIME_W{1'b0}}, a};
      mplier  <= b;
    end else if (running) begin
      acc     <= product;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      step    <= step + 3'd1;
      running <= !done;
    end
  end

endmodule

// File: rtl/parking_billing.sv
// Exit billing: fee = min((now - entry) mod 256 * RATE, 255), computed serially over 8 clocks.
// Optional grace window enabled by defining PARKING_BILLING_GRACE_EN.
module parking_billing
  import parking_pkg::*;
#(
  parameter logic [7:0] RATE  = 8'd3,
  parameter logic [7:0] GRACE = 8'd5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   TimeData,
  input  logic [7:0]   data_P,
  input  logic [7:0]   data_Q,
  input  logic         exit_req,
  input  logic         exit_slot,
  output logic [7:0]   fee,
  output logic         fee_valid,
  output logic         busy,
  output logic         error
);

  bill_state_e          state, state_nxt;
  logic [TIME_W-1:0]    entry, duration, fee_nxt;
  logic                 fee_valid_nxt, busy_nxt, error_nxt;
  logic                 accept, mult_start, mult_done;
  logic [2*TIME_W-1:0]  product;

  assign entry      = (exit_slot == SLOT_Q) ? data_Q : data_P;
  assign duration   = TimeData - entry;  // modular: wrap-around handled for free
  assign accept     = (state == IDLE) && exit_req;
  assign mult_start = accept && (entry != '0);

  fee_mult u_mult (
    .clock   (clock),
    .reset   (reset),
    .start   (mult_start),
    .a       (duration),
    .b       (RATE),
    .done    (mult_done),
    .product (product)
  );

`ifdef PARKING_BILLING_GRACE_EN
  logic grace_hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          grace_hit <= 1'b0;
    else if (mult_start) grace_hit <= (duration <= GRACE);
  end
`endif

  always_comb begin
    state_nxt     = state;
    fee_nxt       = fee;
    fee_valid_nxt = 1'b0;
    busy_nxt      = busy;
    error_nxt     = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (accept) begin
          if (entry == '0) begin
            error_nxt = 1'b1;
          end else begin
            state_nxt = CALC;
            busy_nxt  = 1'b1;
          end
        end
      end
      CALC: begin
        busy_nxt = 1'b1;
        if (mult_done) begin
          state_nxt     = DONE;
          fee_valid_nxt = 1'b1;
          fee_nxt       = sat_fee(product);
`ifdef PARKING_BILLING_GRACE_EN
          if (grace_hit) fee_nxt = '0;
`endif
        end
      end
      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fee       <= '0;
      fee_valid <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      fee       <= fee_nxt;
      fee_valid <= fee_valid_nxt;
      busy      <= busy_nxt;
      error     <= error_nxt;
    end
  end

endmodule

// File: tb/tb_parking_billing.sv
// Randomized and directed checks of parking_billing against a plain-arithmetic fee model.
module tb_parking_billing;

  localparam logic [7:0] RATE  = 8'd3;
  localparam logic [7:0] GRACE = 8'd5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] TimeData = '0, data_P = '0, data_Q = '0;
  logic       exit_req = 1'b0, exit_slot = 1'b0;
  logic [7:0] fee;
  logic       fee_valid, busy, error;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] fee_hold = '0;

  parking_billing #(.RATE(RATE), .GRACE(GRACE)) dut (
    .clock     (clock),
    .reset     (reset),
    .TimeData  (TimeData),
    .data_P    (data_P),
    .data_Q    (data_Q),
    .exit_req  (exit_req),
    .exit_slot (exit_slot),
    .fee       (fee),
    .fee_valid (fee_valid),
    .busy      (busy),
    .error     (error)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] model_fee(input logic [7:0] entry, input logic [7:0] now);
    int dur;
    int prod;
    dur  = (int'(now) - int'(entry) + 256) % 256;
    prod = dur * int'(RATE);
`ifdef PARKING_BILLING_GRACE_EN
    if (dur <= int'(GRACE)) return 8'd0;
`endif
    if (prod > 255) return 8'd255;
    return 8'(prod);
  endfunction

  // Drives a request; caller must be at a falling edge.
  task automatic issue(input logic slot, input logic [7:0] p, input logic [7:0] q, input logic [7:0] t);
    data_P = p; data_Q = q; TimeData = t; exit_slot = slot; exit_req = 1'b1;
  endtask

  // Observes 12 cycles after the accepting edge and checks the whole response.
  // With intrude set, a second (empty-slot) request is pulsed mid-CALC and must be ignored.
  task automatic collect(input logic slot, input logic [7:0] p, input logic [7:0] q,
                         input logic [7:0] t, input bit intrude, input string name);
    logic [7:0] entry, exp_fee, fee_at_fv;
    int err_cnt, first_err, fv_cnt, first_fv, busy_cnt;
    entry = slot ? q : p;
    exp_fee = model_fee(entry, t);
    err_cnt = 0; first_err = -1; fv_cnt = 0; first_fv = -1; busy_cnt = 0; fee_at_fv = 'x;
    @(negedge clock);
    exit_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (error)     begin err_cnt++; if (first_err < 0) first_err = k; end
      if (fee_valid) begin fv_cnt++;  if (first_fv  < 0) begin first_fv = k; fee_at_fv = fee; end end
      if (busy) busy_cnt++;
      if (intrude && k == 3) begin data_P = '0; data_Q = '0; exit_req = 1'b1; end
      @(negedge clock);
      exit_req = 1'b0;
    end
    if (entry == 8'd0) begin
      vectors++;
      if (err_cnt !== 1 || first_err !== 0) begin
        miscompares++;
        $display("FAIL %s error pulses: got %0d at cycle %0d, want 1 at cycle 0", name, err_cnt, first_err);
      end
      vectors++;
      if (fv_cnt !== 0 || busy_cnt !== 0) begin
        miscompares++;
        $display("FAIL %s empty slot activity: fee_valid=%0d busy=%0d, want 0/0", name, fv_cnt, busy_cnt);
      end
      vectors++;
      if (fee !== fee_hold) begin
        miscompares++;
        $display("FAIL %s fee disturbed: got %0d want %0d", name, fee, fee_hold);
      end
    end else begin
      vectors++;
      if (fv_cnt !== 1 || first_fv !== 8) begin
        miscompares++;
        $display("FAIL %s fee_valid: got %0d pulses first at %0d, want 1 at 8", name, fv_cnt, first_fv);
      end
      vectors++;
      if (fee_at_fv !== exp_fee) begin
        miscompares++;
        $display("FAIL %s fee: got %0d want %0d", name, fee_at_fv, exp_fee);
      end
      vectors++;
      if (busy_cnt !== 9 || err_cnt !== 0) begin
        miscompares++;
        $display("FAIL %s busy cycles/errors: got %0d/%0d want 9/0", name, busy_cnt, err_cnt);
      end
      vectors++;
      if (fee !== exp_fee) begin
        miscompares++;
        $display("FAIL %s fee hold: got %0d want %0d", name, fee, exp_fee);
      end
      fee_hold = exp_fee;
    end
  endtask

  task automatic do_request(input logic slot, input logic [7:0] p, input logic [7:0] q,
                            input logic [7:0] t, input string name);
    @(negedge clock);
    issue(slot, p, q, t);
    collect(slot, p, q, t, 1'b0, name);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    vectors++;
    if ({fee, fee_valid, busy, error} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_state: got fee=%0d fv=%b busy=%b err=%b want all 0", fee, fee_valid, busy, error);
    end
    // First rising edge after release must already accept.
    reset = 1'b1;
    issue(1'b0, 8'd10, 8'd0, 8'd20);
    collect(1'b0, 8'd10, 8'd0, 8'd20, 1'b0, "first_after_reset");
  endtask

  task automatic test_directed;
    do_request(1'b0, 8'd10,  8'd0,   8'd20,  "basic_p");
    do_request(1'b1, 8'd0,   8'd250, 8'd4,   "wrap_q");
    do_request(1'b0, 8'd1,   8'd0,   8'd200, "saturate");
    do_request(1'b1, 8'd7,   8'd0,   8'd50,  "empty_q");
    do_request(1'b0, 8'd100, 8'd0,   8'd105, "dur5");
    do_request(1'b0, 8'd100, 8'd0,   8'd106, "dur6");
    do_request(1'b1, 8'd3,   8'd200, 8'd200, "dur0");
  endtask

  task automatic test_ignored_request;
    @(negedge clock);
    issue(1'b1, 8'd0, 8'd40, 8'd90);
    collect(1'b1, 8'd0, 8'd40, 8'd90, 1'b1, "ignored_mid_calc");
  endtask

  task automatic test_reset_mid_calc;
    int fv_cnt, busy_cnt;
    do_request(1'b0, 8'd1, 8'd0, 8'd200, "pre_reset");  // leaves fee nonzero
    @(negedge clock);
    issue(1'b0, 8'd20, 8'd0, 8'd60);
    @(negedge clock);
    exit_req = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    vectors++;
    if ({fee, fee_valid, busy, error} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_mid_calc: got fee=%0d fv=%b busy=%b err=%b want all 0", fee, fee_valid, busy, error);
    end
    fee_hold = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    fv_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (fee_valid) fv_cnt++;
      if (busy) busy_cnt++;
    end
    vectors++;
    if (fv_cnt !== 0 || busy_cnt !== 0 || fee !== 8'd0) begin
      miscompares++;
      $display("FAIL no_resume: fv=%0d busy=%0d fee=%0d want 0/0/0", fv_cnt, busy_cnt, fee);
    end
    do_request(1'b1, 8'd0, 8'd30, 8'd45, "after_reset");
  endtask

  task automatic test_random;
    logic slot;
    logic [7:0] p, q, t;
    for (int i = 0; i < 24; i++) begin
      slot = 1'($urandom_range(0, 1));
      p = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      q = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      // Bias half of the cases toward short durations around the grace/small-fee region.
      if (i % 2 == 0) t = (slot ? q : p) + 8'($urandom_range(0, 12));
      else            t = 8'($urandom_range(0, 255));
      do_request(slot, p, q, t, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_request();
    test_reset_mid_calc();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parking_billing.md
PARKING_BILLING -- requirements
Module: parking_billing

Interface
REQ-001 Parameter RATE, default 8'd3, fee units charged per time unit of parked duration.
REQ-002 Parameter GRACE, default 8'd5, grace duration in time units (used only when the macro in REQ-021 is defined).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 TimeData  input  8  current time, same time base as the entry times.
REQ-006 data_P  input  8  entry time of slot P, from the controller's P register; 0 = slot empty.
REQ-007 data_Q  input  8  entry time of slot Q, from the controller's Q register; 0 = slot empty.
REQ-008 exit_req  input  1  one-cycle request to bill a departing car.
REQ-009 exit_slot  input  1  slot selector sampled with exit_req: 0 = P, 1 = Q.
REQ-010 fee  output  8  computed fee; holds its value until the next accepted request or reset.
REQ-011 fee_valid  output  1  one-cycle pulse marking fee as new.
REQ-012 busy  output  1  high while a computation is in progress.
REQ-013 error  output  1  one-cycle pulse when a request targets an empty slot.

Function
REQ-014 FSM states: IDLE, CALC, DONE; all outputs are registered.
REQ-015 exit_req is accepted only on an edge where state = IDLE; exit_req in CALC or DONE is ignored (no queuing).
REQ-016 On acceptance with a selected entry of 0: error = 1 for the next cycle, fee unchanged, state stays IDLE.
REQ-017 On acceptance with a nonzero entry, the following are latched on that edge (edge 0):
 - duration = (TimeData - entry) mod 256, i.e. time wrap-around is handled by modular subtraction;
 - state goes to CALC, busy = 1, step counter = 0.
REQ-018 CALC performs an 8-step shift-add multiply duration x RATE into a 16-bit accumulator, one step per edge (edges 1-8).
REQ-019 Edge 8 transitions to DONE:
 - fee = 255 if the product exceeds 255, else product[7:0];
 - fee_valid = 1.
REQ-020 Edge 9 transitions to IDLE: fee_valid = 0, busy = 0. Latency from the accepting edge to the fee_valid edge is exactly 8 cycles; a new request is accepted from edge 10 onward.

Configuration
REQ-021 When macro PARKING_BILLING_GRACE_EN is defined:
 - duration <= GRACE yields fee = 0;
 - timing is identical to REQ-018..REQ-020.
 When the macro is undefined, the GRACE parameter is unused and no grace logic is present.

Reset
REQ-022 Asserting reset (low) at any time, including mid-CALC:
 - forces state = IDLE;
 - sets fee = 0, fee_valid = 0, busy = 0, error = 0;
 - clears the accumulator and step counter.
 Any in-flight computation is discarded and does not resume.
REQ-023 The first request is accepted on the first rising edge after reset deasserts.

Structure
REQ-024 Shared package parking_pkg holds:
 - the billing state enum (IDLE/CALC/DONE);
 - the slot encodings SLOT_P = 0 and SLOT_Q = 1;
 - constants TIME_W = 8 and FEE_MAX = 8'd255.
REQ-025 One sub-module, fee_mult (the 8-step serial shift-add multiplier with start/done), is instantiated once.

Verification
REQ-026 data_P = 10, TimeData = 20, exit_slot = 0, pulse exit_req -> fee_valid exactly 8 cycles later with fee = 30; busy high for 9 cycles.
REQ-027 data_Q = 250, TimeData = 4, exit_slot = 1 -> duration 10 (wrap-around), fee = 30.
REQ-028 data_P = 1, TimeData = 200, RATE = 3 -> product 597 saturates, fee = 255.
REQ-029 data_Q = 0, request on slot Q -> error pulse for 1 cycle, no fee_valid, busy stays 0; a second exit_req issued during CALC of a valid request is ignored.
REQ-030 Reset asserted at step 4 of CALC -> all outputs 0 immediately, no fee_valid afterwards; a fresh request after release completes normally.
REQ-031 With PARKING_BILLING_GRACE_EN defined, duration 5 -> fee = 0 and duration 6 -> fee = 18; without the macro, duration 5 -> fee = 15.
